uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter PAYLOAD_BYTES, default 16, number of payload bytes per frame.
REQ-002 Parameter CRC_INIT, default 16'hFFFF, CRC-16 seed value.
REQ-003 CLK  input  1  system clock, 16 MHz; single clock domain.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 rx_frame_n  input  1  frame-enable from pin, active-low, asynchronous to CLK.
REQ-006 rx_data_ready  input  1  one-cycle strobe from uart_rx; byte valid.
REQ-007 rx_data  input  8  received byte; valid while rx_data_ready is high.
REQ-008 payload_o  output  8*PAYLOAD_BYTES  last good payload; byte 0 in bits [7:0].
REQ-009 frame_valid_o  output  1  one-cycle pulse; payload_o updated, CRC good.
REQ-010 crc_error_o  output  1  one-cycle pulse; length correct, CRC mismatch.
REQ-011 length_error_o  output  1  one-cycle pulse; frame ended with byte count != PAYLOAD_BYTES+2.
REQ-012 busy_o  output  1  high while a frame is being received or checked.

Function
REQ-013 The block SHALL pass rx_frame_n through a 2-flop synchronizer; frame_active = synchronized value inverted.
REQ-014 The FSM SHALL have states IDLE, RECEIVE, OVERFLOW and CHECK.
- IDLE -> RECEIVE when frame_active is seen; byte count cleared to 0; CRC seeded with CRC_INIT.
- RECEIVE: each rx_data_ready stores the byte at the count index and increments the count.
- RECEIVE: bytes 0..PAYLOAD_BYTES-1 also update the running CRC.
- RECEIVE -> OVERFLOW when a byte arrives while count == PAYLOAD_BYTES+2; that byte is dropped.
- RECEIVE -> CHECK when frame_active falls; -> IDLE instead if count != PAYLOAD_BYTES+2, with a length_error_o pulse.
- OVERFLOW: ignore bytes; on frame_active fall -> IDLE with a length_error_o pulse.
- CHECK lasts 1 cycle, then -> IDLE.
REQ-015 Bytes PAYLOAD_BYTES and PAYLOAD_BYTES+1 SHALL form the received CRC, high byte first.
REQ-016 CRC SHALL be CRC-16/CCITT-FALSE: poly 0x1021, MSB-first, no reflection, no final XOR, one byte per cycle.
REQ-017 In CHECK, on CRC match: the working buffer SHALL be copied to payload_o and frame_valid_o SHALL pulse. On mismatch: crc_error_o pulses and payload_o is unchanged.
REQ-018 Latency SHALL be exactly 1 cycle from the cycle the falling frame_active is seen in RECEIVE to the result pulse.
REQ-019 If rx_data_ready coincides with the cycle frame_active is seen falling, the byte SHALL be accepted before the length check.
REQ-020 rx_data_ready in IDLE or CHECK SHALL be ignored.
REQ-021 A frame with zero bytes SHALL produce a length_error_o pulse.
REQ-022 At most one of frame_valid_o, crc_error_o and length_error_o SHALL be high in any cycle.
REQ-023 busy_o SHALL be high in RECEIVE, OVERFLOW and CHECK, and low in IDLE.
REQ-024 Reception SHALL use no payload bytes before the falling edge of frame_active; payload_o SHALL never show a partial frame.

Reset
REQ-025 On RST: FSM -> IDLE; count = 0; CRC = CRC_INIT; synchronizer flops = 1 (inactive).
REQ-026 On RST: payload_o = 0; frame_valid_o, crc_error_o, length_error_o and busy_o = 0.
REQ-027 RST asserted mid-frame SHALL discard the frame with no error pulse.
- After RST, a still-asserted rx_frame_n starts a fresh frame from IDLE.

Structure
REQ-028 A shared package SHALL hold: FSM state encoding, CRC_POLY = 16'h1021, FRAME_OVERHEAD = 2.
REQ-029 The byte-wise CRC update SHALL be a sub-module crc16_ccitt_byte: inputs crc_in[15:0] and data[7:0], output crc_out[15:0]; combinational, reused by the transmit framer.
REQ-030 The working buffer SHALL be separate from the payload_o register.

Verification
REQ-031 Unit test of crc16_ccitt_byte: "123456789" fed one byte per step from 0xFFFF -> 0x29B1.
REQ-032 Good frame:
- Stimulus: payload 0x00..0x0F plus the model CRC, high byte first.
- Required: frame_valid_o pulses once; payload_o[7:0] = 0x00 and payload_o[127:120] = 0x0F.
REQ-033 Same frame with the CRC low byte XOR 0x01 -> crc_error_o pulses once; payload_o keeps its previous value.
REQ-034 Length errors:
- 17 bytes -> length_error_o pulses once.
- 20 bytes -> enters OVERFLOW; length_error_o pulses once at frame end.
REQ-035 Reset and boundary cases:
- RST pulsed after byte 5, then a complete good frame -> only frame_valid_o pulses.
- Byte 17's rx_data_ready in the same cycle as the synchronized frame end -> frame_valid_o.

Source files
------------

// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the framed UART receiver and its CRC helper.
package uart_frame_rx_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECEIVE  = 2'd1,
        ST_OVERFLOW = 2'd2,
        ST_CHECK    = 2'd3
    } rx_state_t;

    // CRC-16/CCITT generator polynomial (x^16 + x^12 + x^5 + 1).
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // Trailing CRC bytes carried after the payload in every frame.
    localparam int FRAME_OVERHEAD = 2;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte step of CRC-16/CCITT-FALSE (MSB first, no reflection).
// Purely combinational so the transmit framer can share it.
module crc16_ccitt_byte
    import uart_frame_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // w_stage[k] is the register value after k bit shifts.
    logic [15:0] w_stage [9];

    // Data byte enters at the top of the register, then eight shifts.
    assign w_stage[0] = crc_in ^ {data, 8'h00};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign w_stage[gi + 1] = w_stage[gi][15]
                                   ? ({w_stage[gi][14:0], 1'b0} ^ CRC_POLY)
                                   : {w_stage[gi][14:0], 1'b0};
        end
    endgenerate

    assign crc_out = w_stage[8];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed byte receiver: collects PAYLOAD_BYTES bytes plus a CRC-16 trailer
// while rx_frame_n is low and publishes the payload only when the CRC matches.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 16,
    parameter logic [15:0] CRC_INIT      = 16'hFFFF
)(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       rx_frame_n,
    input  logic                       rx_data_ready,
    input  logic [7:0]                 rx_data,
    output logic [8*PAYLOAD_BYTES-1:0] payload_o,
    output logic                       frame_valid_o,
    output logic                       crc_error_o,
    output logic                       length_error_o,
    output logic                       busy_o
);

    localparam int FRAME_LEN = PAYLOAD_BYTES + FRAME_OVERHEAD;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_PAY  = CW'(PAYLOAD_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

    logic                       r_sync1;
    logic                       r_sync2;
    logic                       w_frame_active;
    rx_state_t                  r_state;
    rx_state_t                  w_state_next;
    logic [CW-1:0]              r_count;
    logic [15:0]                r_crc;
    logic [15:0]                r_rx_crc;
    logic [15:0]                w_crc_step;
    logic [15:0]                w_rx_crc_final;
    logic [8*PAYLOAD_BYTES-1:0] r_buf;
    logic [8*PAYLOAD_BYTES-1:0] r_payload;
    logic                       r_frame_valid;
    logic                       r_crc_error;
    logic                       r_length_error;
    logic                       w_take;
    logic                       w_start;
    logic                       w_len_ok;
    logic                       w_crc_match;
    logic                       w_valid_next;
    logic                       w_crc_err_next;
    logic                       w_len_err_next;

    crc16_ccitt_byte u_crc (
        .crc_in  (r_crc),
        .data    (rx_data),
        .crc_out (w_crc_step)
    );

    // Two-flop synchronizer for the asynchronous frame enable; idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_frame_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_frame_active = ~r_sync2;

    // A byte is stored only in RECEIVE and only while there is room for it.
    assign w_take = (r_state == ST_RECEIVE) && rx_data_ready && (r_count != CNT_FULL);

    // A byte arriving together with the frame end still counts toward the length.
    assign w_len_ok = ((r_count == CNT_FULL) && !rx_data_ready) ||
                      ((r_count == CNT_LAST) && rx_data_ready);

    // The final CRC byte may land in the same cycle as the frame end.
    assign w_rx_crc_final = (w_take && (r_count == CNT_LAST)) ? {r_rx_crc[7:0], rx_data}
                                                               : r_rx_crc;
    assign w_crc_match    = (r_crc == w_rx_crc_final);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the verdict for the frame that is ending.
    always_comb begin
        w_state_next   = r_state;
        w_start        = 1'b0;
        w_valid_next   = 1'b0;
        w_crc_err_next = 1'b0;
        w_len_err_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_frame_active) begin
                    w_state_next = ST_RECEIVE;
                    w_start      = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (!w_frame_active) begin
                    if (w_len_ok) begin
                        w_state_next   = ST_CHECK;
                        w_valid_next   = w_crc_match;
                        w_crc_err_next = !w_crc_match;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_len_err_next = 1'b1;
                    end
                end else if (rx_data_ready && (r_count == CNT_FULL)) begin
                    w_state_next = ST_OVERFLOW;
                end
            end
            ST_OVERFLOW: begin
                if (!w_frame_active) begin
                    w_state_next   = ST_IDLE;
                    w_len_err_next = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte counter, running CRC over the payload, and the received CRC trailer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count  <= '0;
            r_crc    <= CRC_INIT;
            r_rx_crc <= '0;
        end else if (w_start) begin
            r_count  <= '0;
            r_crc    <= CRC_INIT;
            r_rx_crc <= '0;
        end else if (w_take) begin
            r_count <= r_count + 1'b1;
            if (r_count < CNT_PAY) begin
                r_crc <= w_crc_step;
            end else begin
                r_rx_crc <= {r_rx_crc[7:0], rx_data};
            end
        end
    end

    // Working payload buffer; contents only matter once a frame is judged good.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (w_take && (r_count == CW'(i))) begin
                r_buf[8*i +: 8] <= rx_data;
            end
        end
    end

    // Result pulses and the published payload, updated only for a good frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_payload      <= '0;
            r_frame_valid  <= 1'b0;
            r_crc_error    <= 1'b0;
            r_length_error <= 1'b0;
        end else begin
            r_frame_valid  <= w_valid_next;
            r_crc_error    <= w_crc_err_next;
            r_length_error <= w_len_err_next;
            if (w_valid_next) begin
                r_payload <= r_buf;
            end
        end
    end

    assign payload_o      = r_payload;
    assign frame_valid_o  = r_frame_valid;
    assign crc_error_o    = r_crc_error;
    assign length_error_o = r_length_error;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: CRC step unit test, table of frames with a
// scoreboard of expected result pulses, and reset / same-cycle-end sequences.
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int NB = 16;
    localparam int PW = 8 * NB;
    localparam int K_VALID = 1;
    localparam int K_CRC   = 2;
    localparam int K_LEN   = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rx_frame_n = 1'b1;
    logic          rx_data_ready = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [PW-1:0] payload_o;
    logic          frame_valid_o;
    logic          crc_error_o;
    logic          length_error_o;
    logic          busy_o;

    logic [15:0]   t_crc_in;
    logic [7:0]    t_data;
    logic [15:0]   t_crc_out;

    uart_frame_rx #(.PAYLOAD_BYTES(NB), .CRC_INIT(16'hFFFF)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .rx_frame_n     (rx_frame_n),
        .rx_data_ready  (rx_data_ready),
        .rx_data        (rx_data),
        .payload_o      (payload_o),
        .frame_valid_o  (frame_valid_o),
        .crc_error_o    (crc_error_o),
        .length_error_o (length_error_o),
        .busy_o         (busy_o)
    );

    crc16_ccitt_byte u_crc_ut (
        .crc_in  (t_crc_in),
        .data    (t_data),
        .crc_out (t_crc_out)
    );

    typedef struct {
        int            kind;
        int            cyc;
        logic [PW-1:0] payload;
    } exp_t;

    typedef struct {
        int nbytes;
        bit bad_crc;
        bit coincide;
        bit seq_data;
        int kind;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[10];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic [PW-1:0] last_good = '0;
    exp_t          mon_e;
    int            mon_kind;
    string         crc_str;
    logic [15:0]   crc_acc;
    logic [15:0]   crc_ref;

    always #31.25 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Bit-serial reference CRC-16/CCITT-FALSE.
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Monitor: every result pulse pops one scoreboard entry.
    always @(negedge CLK) begin
        if (frame_valid_o || crc_error_o || length_error_o) begin
            mon_kind = frame_valid_o ? K_VALID : (crc_error_o ? K_CRC : K_LEN);
            chk("one_hot", PW'($countones({frame_valid_o, crc_error_o, length_error_o})), 1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("frame result: kind=%0d cycle=%0d payload=%h", mon_kind, cyc, payload_o);
                chk("kind", PW'(mon_kind), PW'(mon_e.kind));
                chk("latency", PW'(cyc), PW'(mon_e.cyc));
                chk("payload", payload_o, mon_e.payload);
            end
        end
    end

    task automatic send_frame(input int nb, input bit bad, input bit coin, input bit seq,
                              input int kind, input bit already_low);
        logic [7:0]    fb[$];
        logic [PW-1:0] pl;
        logic [15:0]   c;
        logic [7:0]    b;
        exp_t          e;
        int            last;
        c  = 16'hFFFF;
        pl = '0;
        for (int i = 0; i < NB; i++) begin
            b = seq ? 8'(i) : 8'($urandom_range(0, 255));
            pl[8*i +: 8] = b;
            c = crc_model(c, b);
            fb.push_back(b);
        end
        fb.push_back(c[15:8]);
        fb.push_back(c[7:0] ^ {7'd0, bad});
        while (fb.size() < nb) fb.push_back(8'($urandom_range(0, 255)));
        e.kind    = kind;
        e.payload = (kind == K_VALID) ? pl : last_good;
        if (kind == K_VALID) last_good = pl;

        if (!already_low) begin
            @(posedge CLK); #1;
            rx_frame_n = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_receive", PW'(busy_o), 1);
        last = coin ? nb - 1 : nb;
        for (int i = 0; i < last; i++) begin
            rx_data = fb[i];
            rx_data_ready = 1'b1;
            @(posedge CLK); #1;
            rx_data_ready = 1'b0;
            @(posedge CLK); #1;
        end
        rx_frame_n = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        // The synchronized end is seen in this cycle; the result follows one cycle later.
        e.cyc = cyc + 1;
        sb.push_back(e);
        if (coin) begin
            rx_data = fb[nb-1];
            rx_data_ready = 1'b1;
        end
        @(posedge CLK); #1;
        rx_data_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_idle", PW'(busy_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{18, 1'b0, 1'b0, 1'b1, K_VALID};
        vecs[1] = '{18, 1'b1, 1'b0, 1'b1, K_CRC};
        vecs[2] = '{17, 1'b0, 1'b0, 1'b0, K_LEN};
        vecs[3] = '{20, 1'b0, 1'b0, 1'b0, K_LEN};
        vecs[4] = '{ 0, 1'b0, 1'b0, 1'b0, K_LEN};
        vecs[5] = '{18, 1'b0, 1'b0, 1'b0, K_VALID};
        vecs[6] = '{18, 1'b0, 1'b1, 1'b0, K_VALID};
        vecs[7] = '{19, 1'b0, 1'b0, 1'b0, K_LEN};
        vecs[8] = '{18, 1'b1, 1'b1, 1'b0, K_CRC};
        vecs[9] = '{19, 1'b0, 1'b1, 1'b0, K_LEN};

        // CRC step unit test on the standard check string.
        crc_str = "123456789";
        crc_acc = 16'hFFFF;
        crc_ref = 16'hFFFF;
        for (int i = 0; i < crc_str.len(); i++) begin
            t_crc_in = crc_acc;
            t_data   = crc_str[i];
            #1;
            crc_ref = crc_model(crc_ref, t_data);
            crc_acc = t_crc_out;
            chk("crc_step", PW'(crc_acc), PW'(crc_ref));
        end
        $display("crc unit: check value %h", crc_acc);
        chk("crc_check", PW'(crc_acc), PW'(16'h29B1));

        // Reset state.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_payload", payload_o, '0);
        chk("reset_valid", PW'(frame_valid_o), 0);
        chk("reset_crc_err", PW'(crc_error_o), 0);
        chk("reset_len_err", PW'(length_error_o), 0);
        chk("reset_busy", PW'(busy_o), 0);
        @(posedge CLK); #1;

        // Table-driven frames.
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].nbytes, vecs[i].bad_crc, vecs[i].coincide,
                       vecs[i].seq_data, vecs[i].kind, 1'b0);
            if (i == 0) begin
                chk("payload_byte0", PW'(payload_o[7:0]), PW'(8'h00));
                chk("payload_byte15", PW'(payload_o[127:120]), PW'(8'h0F));
            end
        end

        // Reset in the middle of a frame: discarded silently, then a fresh good frame.
        @(posedge CLK); #1;
        rx_frame_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            rx_data = 8'(8'hA0 + i);
            rx_data_ready = 1'b1;
            @(posedge CLK); #1;
            rx_data_ready = 1'b0;
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        last_good = '0;
        chk("midreset_busy", PW'(busy_o), 0);
        chk("midreset_payload", payload_o, '0);
        send_frame(18, 1'b0, 1'b0, 1'b0, K_VALID, 1'b1);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge CLK);
        #1;
        chk("scoreboard_drained", PW'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
